t_reg_arbiter: RTL

Arbitrated write controller for a shared WIDTH-bit register built from T flip-flops. Up to NREQ requesters each present a value to load. The block grants one requester at a time, round-robin. It derives the toggle pattern `t = d ^ q` so the T-flip-flop bank behaves as a loadable D register, then acknowledges completion. It sits between the requesting datapath blocks and the T-flip-flop register bank, which it contains.

---
 rtl/t_reg_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/t_reg_arbiter.sv
// t_reg_arbiter: round-robin arbitrated loader for a shared T-flip-flop register.
// Optional build macro: TREG_VERIFY_EN (adds a CHECK state and a sticky err).
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   req    per-requester level write request
//   wdata  requester i data in [i*WIDTH +: WIDTH]
//   gnt    one-hot grant, LOAD through DONE
//   done   one-cycle completion pulse to the winner
//   busy   high whenever not IDLE
//   tog    toggle vector into the bank, zero outside TOGGLE
//   q      T-flip-flop bank contents
//   err    sticky verify mismatch (0 without TREG_VERIFY_EN)
module t_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      tog,
  output logic [WIDTH-1:0]      q,
  output logic                  err
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    TOGGLE = 3'd2,
`ifdef TREG_VERIFY_EN
    CHECK  = 3'd4,
`endif
    DONE   = 3'd3
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   j;
  logic [PW:0]     s;
  logic            any;
  logic [NREQ-1:0] win_oh;
  logic [WIDTH-1:0] d_lat;

  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;

  // First high req at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick = ptr;
    any  = 1'b0;
    s    = '0;
    j    = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(NREQ))
        s = s - (PW+1)'(NREQ);
      j = s[PW-1:0];
      if (!any && req[j]) begin
        pick = j;
        any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      d_lat <= '0;
      q     <= '0;
    end else begin
      state <= nxt;
      q     <= q ^ tog;
      if (state == IDLE && any)
        win <= pick;
      if (state == LOAD)
        d_lat <= wdata[int'(win)*WIDTH +: WIDTH];
      if (state == DONE)
        ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

`ifdef TREG_VERIFY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (state == CHECK && q != d_lat)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    nxt  = state;
    gnt  = '0;
    done = '0;
    tog  = '0;
    busy = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any)
          nxt = LOAD;
      end
      LOAD: begin
        gnt = win_oh;
        nxt = TOGGLE;
      end
      TOGGLE: begin
        gnt = win_oh;
        tog = d_lat ^ q;
`ifdef TREG_VERIFY_EN
        nxt = CHECK;
`else
        nxt = DONE;
`endif
      end
`ifdef TREG_VERIFY_EN
      CHECK: begin
        gnt = win_oh;
        nxt = DONE;
      end
`endif
      DONE: begin
        gnt  = win_oh;
        done = win_oh;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
